// File: rtl/mem_unit.sv
// Drum main store: requests wait for their sector to rotate under the heads,
// then perform the access and return a single-cycle completion pulse.
module mem_unit #(
    parameter int WORD_W   = 31,
    parameter int ADDR_W   = 10,
    parameter int SECTOR_W = 5,
    parameter int CPS      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read_from_pulse,
    input  logic                mem_write_from_op,
    input  logic [ADDR_W-1:0]   addr_from_sel,
    input  logic [WORD_W-1:0]   data_from_ac,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [WORD_W-1:0]   load_data,
    output logic                mem_read_reply_to_pulse,
    output logic                mem_write_reply_to_op,
    output logic [WORD_W-1:0]   data_to_ac,
    output logic                busy,
    output logic [SECTOR_W-1:0] drum_pos,
    output logic                req_err
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TICK_W = (CPS > 2) ? $clog2(CPS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CPS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_RD = 2'd1;
    localparam logic [1:0] ST_WAIT_WR = 2'd2;

    logic [WORD_W-1:0]   mem_array [DEPTH];

    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SECTOR_W-1:0] drum_pos_q, drum_pos_d;
    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                rd_reply_q, rd_reply_d;
    logic                wr_reply_q, wr_reply_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                req_any_s;
    logic                at_access_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [WORD_W-1:0]   mem_wdata_s;

    assign req_any_s   = mem_read_from_pulse | mem_write_from_op;
    // Match is only evaluated in WAIT_*, so a request accepted on its own
    // access-point edge naturally waits a full revolution.
    assign at_access_s = (tick_q == TICK_LAST) &&
                         (drum_pos_q == addr_q[SECTOR_W-1:0]);

    // Free-running drum rotation: tick within a sector, sector under the heads.
    always_comb begin
        tick_d     = tick_q;
        drum_pos_d = drum_pos_q;
        if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            drum_pos_d = drum_pos_q + SECTOR_W'(1);
        end else begin
            tick_d     = tick_q + TICK_W'(1);
        end
    end

    // Request acceptance, access-point handling, loader and refusal tracking.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
        rd_reply_d  = 1'b0;
        wr_reply_d  = 1'b0;
        err_d       = err_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_q;
        mem_wdata_s = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_read_from_pulse) begin
                    state_d = ST_WAIT_RD;
                    addr_d  = addr_from_sel;
                end else if (mem_write_from_op) begin
                    state_d = ST_WAIT_WR;
                    addr_d  = addr_from_sel;
                    wdata_d = data_from_ac;
                end else begin
                    state_d = ST_IDLE;
                end
                if (load_en && !req_any_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = load_addr;
                    mem_wdata_s = load_data;
                end else begin
                    mem_we_s    = 1'b0;
                end
                err_d = err_q | (mem_read_from_pulse & mem_write_from_op) |
                        (load_en & req_any_s);
            end
            ST_WAIT_RD: begin
                err_d = err_q | req_any_s | load_en;
                if (at_access_s) begin
                    dout_d     = mem_array[addr_q];
                    rd_reply_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_WAIT_RD;
                end
            end
            ST_WAIT_WR: begin
                err_d = err_q | req_any_s | load_en;
                if (at_access_s) begin
                    mem_we_s   = 1'b1;
                    wr_reply_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_WAIT_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) | rd_reply_d | wr_reply_d;
    end

    // Control and output registers; reset abandons any pending access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q     <= '0;
            drum_pos_q <= '0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            rd_reply_q <= 1'b0;
            wr_reply_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            drum_pos_q <= drum_pos_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            rd_reply_q <= rd_reply_d;
            wr_reply_q <= wr_reply_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage array: deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_array[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign mem_read_reply_to_pulse = rd_reply_q;
    assign mem_write_reply_to_op   = wr_reply_q;
    assign data_to_ac              = dout_q;
    assign busy                    = busy_q;
    assign drum_pos                = drum_pos_q;
    assign req_err                 = err_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit with a cycle-indexed reference model of the drum store.
module tb_mem_unit;
    localparam int WORD_W   = 31;
    localparam int ADDR_W   = 10;
    localparam int SECTOR_W = 5;
    localparam int CPS      = 4;
    localparam int NSEC     = 32;
    localparam int REV      = CPS * NSEC;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                mem_read_from_pulse = 1'b0;
    logic                mem_write_from_op = 1'b0;
    logic [ADDR_W-1:0]   addr_from_sel = '0;
    logic [WORD_W-1:0]   data_from_ac = '0;
    logic                load_en = 1'b0;
    logic [ADDR_W-1:0]   load_addr = '0;
    logic [WORD_W-1:0]   load_data = '0;
    logic                mem_read_reply_to_pulse;
    logic                mem_write_reply_to_op;
    logic [WORD_W-1:0]   data_to_ac;
    logic                busy;
    logic [SECTOR_W-1:0] drum_pos;
    logic                req_err;

    always #5 clk = ~clk;

    mem_unit #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .SECTOR_W(SECTOR_W), .CPS(CPS)) dut (
        .clk(clk), .reset(reset),
        .mem_read_from_pulse(mem_read_from_pulse), .mem_write_from_op(mem_write_from_op),
        .addr_from_sel(addr_from_sel), .data_from_ac(data_from_ac),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .mem_read_reply_to_pulse(mem_read_reply_to_pulse),
        .mem_write_reply_to_op(mem_write_reply_to_op),
        .data_to_ac(data_to_ac), .busy(busy), .drum_pos(drum_pos), .req_err(req_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: k is the cycle index since reset release.
    int                k;
    int                pend;      // 0 none, 1 read, 2 write
    int                due;       // cycle whose closing edge performs the access
    logic [ADDR_W-1:0] m_addr;
    logic [WORD_W-1:0] m_data;
    logic              e_rd, e_wr, e_busy, e_err;
    logic [WORD_W-1:0] e_dout;
    logic [WORD_W-1:0] mm [int];

    logic              s_rd, s_wr, s_busy, s_err;
    logic [WORD_W-1:0] s_dout;
    logic [SECTOR_W-1:0] s_pos;
    int                s_k;

    function automatic int acc_cycle(input int a, input logic [ADDR_W-1:0] ad);
        int c;
        c = a + 1;
        while (!(((c % CPS) == CPS - 1) && (((c / CPS) % NSEC) == int'(ad[SECTOR_W-1:0]))))
            c++;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; pend = 0; due = 0; m_addr = '0; m_data = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_dout = '0;
    endtask

    task automatic model_update(input logic rd, input logic wr, input logic [ADDR_W-1:0] ad,
                                input logic [WORD_W-1:0] wd, input logic ld,
                                input logic [ADDR_W-1:0] la, input logic [WORD_W-1:0] ldd);
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (pend != 0) begin
            if (rd || wr || ld) e_err = 1'b1;
            if (k == due) begin
                if (pend == 1) begin
                    e_rd = 1'b1;
                    e_dout = mm[int'(m_addr)];
                end else begin
                    e_wr = 1'b1;
                    mm[int'(m_addr)] = m_data;
                end
                pend = 0;
            end
        end else begin
            if (rd) begin
                pend = 1; m_addr = ad; due = acc_cycle(k, ad);
                if (wr) e_err = 1'b1;
            end else if (wr) begin
                pend = 2; m_addr = ad; m_data = wd; due = acc_cycle(k, ad);
            end
            if (ld) begin
                if (rd || wr) e_err = 1'b1;
                else mm[int'(la)] = ldd;
            end
        end
        k++;
        e_busy = (pend != 0) || e_rd || e_wr;
    endtask

    task automatic step(input logic rd, input logic wr, input logic [ADDR_W-1:0] ad,
                        input logic [WORD_W-1:0] wd, input logic ld,
                        input logic [ADDR_W-1:0] la, input logic [WORD_W-1:0] ldd);
        logic [SECTOR_W-1:0] e_pos;
        mem_read_from_pulse = rd; mem_write_from_op = wr;
        addr_from_sel = ad; data_from_ac = wd;
        load_en = ld; load_addr = la; load_data = ldd;
        @(negedge clk);
        s_k = k; s_rd = mem_read_reply_to_pulse; s_wr = mem_write_reply_to_op;
        s_busy = busy; s_err = req_err; s_dout = data_to_ac; s_pos = drum_pos;
        e_pos = SECTOR_W'((k / CPS) % NSEC);
        n_vec++;
        if (s_rd !== e_rd || s_wr !== e_wr || s_busy !== e_busy || s_err !== e_err ||
            s_dout !== e_dout || s_pos !== e_pos) begin
            n_bad++;
            $display("FAIL cycle %0d: rd %b/%b wr %b/%b busy %b/%b err %b/%b data %h/%h pos %0d/%0d (got/expected)",
                     k, s_rd, e_rd, s_wr, e_wr, s_busy, e_busy, s_err, e_err,
                     s_dout, e_dout, s_pos, e_pos);
        end
        model_update(rd, wr, ad, wd, ld, la, ldd);
        @(posedge clk);
        #1;
        mem_read_from_pulse = 1'b0; mem_write_from_op = 1'b0; load_en = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 10'h000, 31'h0, 1'b0, 10'h000, 31'h0);
    endtask

    task automatic wait_reply(input int budget, output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (!(s_rd || s_wr) && n < budget);
        if (!(s_rd || s_wr)) chk("reply_timeout", 64'd0, 64'd1);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        mem_read_from_pulse = 1'b0; mem_write_from_op = 1'b0; load_en = 1'b0;
        #1;
        chk("rst_rd_reply", 64'(mem_read_reply_to_pulse), 64'd0);
        chk("rst_wr_reply", 64'(mem_write_reply_to_op), 64'd0);
        chk("rst_data", 64'(data_to_ac), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pos", 64'(drum_pos), 64'd0);
        chk("rst_err", 64'(req_err), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nrd, nwr;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Loads in cycles 0..3, drum_pos must read 0,0,0,0,1 over cycles 0..4.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: step(1'b0, 1'b0, 10'h000, 31'h0, 1'b1, 10'h043, 31'h1234567);
                1: step(1'b0, 1'b0, 10'h000, 31'h0, 1'b1, 10'h040, 31'h5A5A5A5);
                2: step(1'b0, 1'b0, 10'h000, 31'h0, 1'b1, 10'h122, 31'h3C3C3C3);
                3: step(1'b0, 1'b0, 10'h000, 31'h0, 1'b1, 10'h3FF, 31'h0000001);
                default: idle();
            endcase
            chk("pos_after_release", 64'(s_pos), (i == 4) ? 64'd1 : 64'd0);
        end

        // Simultaneous read+write: read of sector 2 serviced, error flagged.
        step(1'b1, 1'b1, 10'h122, 31'h2222222, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("dual_read_latency", 64'(n), 64'd7);
        chk("dual_read_data", 64'(s_dout), 64'h3C3C3C3);
        chk("dual_err", 64'(s_err), 64'd1);
        step(1'b1, 1'b0, 10'h3FF, 31'h0, 1'b0, 10'h000, 31'h0);
        idle();
        idle();
        async_reset();

        // Read 0x043 at tick 0 / sector 0: reply only in cycle 16.
        step(1'b1, 1'b0, 10'h043, 31'h0, 1'b0, 10'h000, 31'h0);
        for (int i = 1; i <= 20; i++) begin
            idle();
            chk("read_busy", 64'(s_busy), (s_k >= 1 && s_k <= 16) ? 64'd1 : 64'd0);
            chk("read_reply", 64'(s_rd), (s_k == 16) ? 64'd1 : 64'd0);
            if (s_k == 16) chk("read_data", 64'(s_dout), 64'h1234567);
        end

        // Write then read back the top word (sector 31).
        step(1'b0, 1'b1, 10'h3FF, 31'h7FFFFFFF, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("write_latency", 64'(n), 64'd107);
        chk("write_reply", 64'(s_wr), 64'd1);
        step(1'b1, 1'b0, 10'h3FF, 31'h0, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("readback_latency", 64'(n), 64'd127);
        chk("readback_data", 64'(s_dout), 64'h7FFFFFFF);

        // Request accepted on its own access-point edge waits a full revolution.
        while ((k % REV) != 3) idle();
        step(1'b1, 1'b0, 10'h040, 31'h0, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("max_latency", 64'(n), 64'd129);
        chk("max_latency_data", 64'(s_dout), 64'h5A5A5A5);

        // Refusals: dual request, read while busy, load while busy.
        step(1'b1, 1'b1, 10'h043, 31'h1111111, 1'b0, 10'h000, 31'h0);
        step(1'b1, 1'b0, 10'h040, 31'h0, 1'b0, 10'h000, 31'h0);
        chk("refuse_err", 64'(s_err), 64'd1);
        step(1'b0, 1'b0, 10'h000, 31'h0, 1'b1, 10'h043, 31'h0);
        nrd = 0;
        nwr = 0;
        for (int i = 0; i < 140; i++) begin
            idle();
            if (s_rd) nrd++;
            if (s_wr) nwr++;
        end
        chk("refuse_rd_count", 64'(nrd), 64'd1);
        chk("refuse_wr_count", 64'(nwr), 64'd0);
        step(1'b1, 1'b0, 10'h043, 31'h0, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("refused_load_data", 64'(s_dout), 64'h1234567);

        // Reset during WAIT_WR abandons the write.
        step(1'b0, 1'b1, 10'h043, 31'h0ABCDEF, 1'b0, 10'h000, 31'h0);
        repeat (5) idle();
        async_reset();
        step(1'b1, 1'b0, 10'h043, 31'h0, 1'b0, 10'h000, 31'h0);
        wait_reply(200, n);
        chk("post_reset_reply_is_read", 64'(s_rd), 64'd1);
        chk("post_reset_latency", 64'(n), 64'd16);
        chk("post_reset_data", 64'(s_dout), 64'h1234567);
        chk("post_reset_err", 64'(s_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_unit.md
# mem_unit

Drum main store for the processor: accepts single-cycle read pulses from the pulse distributor and write pulses from the operation unit, and waits for the addressed sector to rotate under the heads. It then performs the access and returns a one-cycle completion pulse. Sits directly downstream of the pulse distributor: it consumes `mem_read` and produces the `mem_read_reply` pulse that advances the distributor's states 2, 4 and 6. Read data goes to the arithmetic controller.

## Interface
- `WORD_W`, 31, word width in bits
- `ADDR_W`, 10, address width; store depth 2**ADDR_W words
- `SECTOR_W`, 5, sectors per track = 2**SECTOR_W; sector = `addr[SECTOR_W-1:0]`
- `CPS`, 4, clock cycles per sector (≥2)

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge
- `reset` input 1: asynchronous, active-high
- `mem_read_from_pulse` input 1: pulse, read request
- `mem_write_from_op` input 1: pulse, write request
- `addr_from_sel` input ADDR_W: address, sampled with the request
- `data_from_ac` input WORD_W: write data, sampled with the write request
- `load_en` input 1: loader write, zero latency, honoured only when idle
- `load_addr` input ADDR_W: loader address
- `load_data` input WORD_W: loader data
- `mem_read_reply_to_pulse` output 1: pulse, read done, data valid
- `mem_write_reply_to_op` output 1: pulse, write done
- `data_to_ac` output WORD_W: last read word, held until the next read completes
- `busy` output 1: request pending
- `drum_pos` output SECTOR_W: current sector under the heads
- `req_err` output 1: sticky, a request was refused

## Operation
- **Rotation.** Counter `tick` counts 0..CPS-1, then wraps. `drum_pos` increments, mod 2**SECTOR_W, on the edge where `tick==CPS-1`. It runs continuously, independent of requests.
- **States.** IDLE, WAIT_RD, WAIT_WR.
- **Leaving IDLE.**
  - `mem_read_from_pulse` high: latch the address and go to WAIT_RD.
  - Otherwise `mem_write_from_op` high: latch the address and data, go to WAIT_WR.
- **Access point.** In WAIT_*, the access point is the edge where `tick==CPS-1 && drum_pos==latched sector`. On that edge:
  - WAIT_RD: `data_to_ac <= mem[addr]` and the read reply is asserted.
  - WAIT_WR: `mem[addr] <= data`, `data_to_ac` unchanged, and the write reply is asserted.
  - The state returns to IDLE.
- **Match checking.** Matching is checked only from the cycle after acceptance. If a request is accepted on its own access-point edge, it waits one full revolution.
- **Refusals that set `req_err`:**
  - Read and write high in the same IDLE cycle: the read is taken, the write is refused.
  - Any request while in WAIT_*: ignored, FSM unaffected.
  - `load_en` while not IDLE, or together with a request: the load is ignored.
- **Loader.** `load_en` in IDLE with no request writes `mem[load_addr] <= load_data` on that edge.
- **Clearing `req_err`.** Only `reset` clears it.
- **Storage.** The array is not reset; its contents survive `reset`.

## Timing
- **Reset values:** `tick`=0, `drum_pos`=0, state IDLE, `busy`=0, both replies 0, `data_to_ac`=0, `req_err`=0.
- **Reset mid-operation:** abandons the pending access with no reply pulse and no memory write.
- **`busy`:** high from the cycle after acceptance through the cycle in which the reply is high. A new request is therefore accepted no earlier than the cycle after the reply.
- **Reply pulses:** registered, exactly one cycle wide, one per accepted request.
- **Read data:** `data_to_ac` changes on the same edge that raises the read reply, so data is valid whenever the reply is high.
- **Latency:** cycles from the acceptance edge to the reply-high cycle lie in 1 .. CPS·2**SECTOR_W; the maximum (128 with defaults) occurs for a request accepted on its own access-point edge.
- **Address bits:** bits above SECTOR_W select the track and do not affect latency.
- **Wrap-around:** `drum_pos` wraps from 2**SECTOR_W-1 to 0 with no gap.

## Test plan
- **Reset defaults:** assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; `drum_pos` reads 0,0,0,0,1 on the first five cycles after release.
- **Read latency:** load `mem[0x043]`=31'h1234567. Read addr 0x043 in cycle 0 after release, i.e. at `tick`=0, `drum_pos`=0. -> access at the cycle-15 edge; reply high in cycle 16 only; `data_to_ac`=31'h1234567; `busy` high cycles 1–16.
- **Write then read back:** write 31'h7FFFFFFF to 0x3FF, then read it -> write reply after the sector-31 match, then read returns 31'h7FFFFFFF.
- **Maximum latency:** request accepted on its own access-point edge -> reply after 128 cycles.
- **Refusals:** read and write in the same cycle -> read serviced, `req_err`=1. A second read while busy -> ignored, only one reply.
- **Reset mid-operation:** reset during WAIT_WR -> no reply, memory unchanged, state IDLE, `req_err`=0.
